// File: rtl/riscv_dbg_rf_access.sv
`default_nettype none
// ============================================================================
// Module      : riscv_dbg_rf_access
// Description : Debug-host initiator for the integer register file debug port.
//               Stalls the core, performs one access (or a read burst when
//               RF_DBG_BURST_EN is defined), then pulses ack.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_dbg_rf_access #(
  parameter int          XLEN          = 32,
  parameter int          AR_BITS       = 5,
  parameter logic [11:0] GPR_BASE      = 12'h000,
  parameter int          STALL_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               we,
  input  logic [AR_BITS-1:0] idx,
  input  logic [XLEN-1:0]    wdata,
`ifdef RF_DBG_BURST_EN
  input  logic [AR_BITS-1:0] len,
  output logic               rvld,
`endif
  output logic               ack,
  output logic               err,
  output logic [XLEN-1:0]    rdata,
  output logic               busy,
  output logic               du_stall_req,
  input  logic               du_stall,
  output logic [11:0]        du_addr,
  output logic               du_we_rf,
  output logic [XLEN-1:0]    du_dato,
  input  logic [XLEN-1:0]    du_dati_rf
);

  localparam int CW = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(STALL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STALL  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [AR_BITS-1:0] idx_q, idx_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               err_d;

  logic               ack_q, err_q, busy_q, stall_req_q, du_we_q;
  logic [11:0]        du_addr_q;
  logic [XLEN-1:0]    du_dato_q, rdata_q;
  logic               wr_now;

`ifdef RF_DBG_BURST_EN
  logic [AR_BITS-1:0] beats_q, beats_d;
  logic               rvld_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
`ifdef RF_DBG_BURST_EN
    beats_d = beats_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = idx;
          wdata_d = wdata;
          cnt_d   = '0;
`ifdef RF_DBG_BURST_EN
          beats_d = we ? '0 : len;
          // Write bursts are rejected without ever touching the core.
          if (we && (len != '0)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else
`endif
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (du_stall) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACCESS: begin
`ifdef RF_DBG_BURST_EN
        if (beats_q != '0) begin
          beats_d = beats_q - 1'b1;
          idx_d   = idx_q + 1'b1;
        end else
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // x0 is hardwired, so its write strobe is suppressed.
  assign wr_now = (state_d == S_ACCESS) && we_d && (idx_d != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
`ifdef RF_DBG_BURST_EN
      beats_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
`ifdef RF_DBG_BURST_EN
      beats_q <= beats_d;
`endif
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      stall_req_q <= 1'b0;
      du_we_q     <= 1'b0;
      du_addr_q   <= GPR_BASE;
      du_dato_q   <= '0;
      rdata_q     <= '0;
`ifdef RF_DBG_BURST_EN
      rvld_q      <= 1'b0;
`endif
    end else begin
      ack_q       <= (state_d == S_DONE);
      err_q       <= err_d;
      busy_q      <= (state_d != S_IDLE);
      stall_req_q <= (state_d == S_STALL) || (state_d == S_ACCESS);
      du_we_q     <= wr_now;
      du_dato_q   <= wr_now ? wdata_d : '0;
      if (state_d == S_ACCESS) begin
        du_addr_q <= {GPR_BASE[11:AR_BITS], idx_d};
      end
      if ((state_q == S_ACCESS) && !we_q) begin
        rdata_q <= du_dati_rf;
      end
`ifdef RF_DBG_BURST_EN
      rvld_q      <= (state_q == S_ACCESS) && !we_q;
`endif
    end
  end

  assign ack          = ack_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign du_stall_req = stall_req_q;
  assign du_we_rf     = du_we_q;
  assign du_addr      = du_addr_q;
  assign du_dato      = du_dato_q;
  assign rdata        = rdata_q;
`ifdef RF_DBG_BURST_EN
  assign rvld         = rvld_q;
`endif

endmodule
`default_nettype wire
